fp_add_seq: RTL and testbench

//   Multicycle single-precision FP add/sub unit for the multicycle datapath.

---
 rtl/fp_add_seq_if.sv | 20 ++
 rtl/fp_add_seq.sv | 152 +++++++++++++++
 tb/tb_fp_add_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp_add_seq_if.sv
// Operand/result bundle for the multicycle FP adder.
// The optional op_count field exists only when FP_ADD_SEQ_OPCNT_EN is defined.
interface fp_add_seq_if;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef FP_ADD_SEQ_OPCNT_EN
  logic [15:0] op_count;

  modport master (output start, sub, a, b, input busy, done, result, op_count);
  modport slave  (input start, sub, a, b, output busy, done, result, op_count);
`else
  modport master (output start, sub, a, b, input busy, done, result);
  modport slave  (input start, sub, a, b, output busy, done, result);
`endif
endinterface

// File: rtl/fp_add_seq.sv
// Multicycle single-precision add/sub: IDLE -> ALIGN -> ADDSUB -> NORM* -> PACK.
// Truncating arithmetic; optional completed-op counter under FP_ADD_SEQ_OPCNT_EN.
module fp_add_seq #(
  parameter int SHIFT_PER_CYC = 1
) (
  input logic       clk,
  input logic       reset,
  fp_add_seq_if.slave bus
);

  localparam logic [4:0] SHIFT_K = 5'(SHIFT_PER_CYC);

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, PACK} stateT;

  stateT       state, nextState;
  logic [31:0] aReg, bReg;
  logic [23:0] alA, alB, man;
  logic [7:0]  expAl, exp;
  logic        sign;
  logic        doneReg;
  logic [31:0] resultReg;

  // Alignment: the smaller-exponent mantissa is shifted right, excess bits dropped.
  logic [7:0]  expA, expB, expDiff;
  logic [23:0] mantA, mantB, shiftSrc, shifted;
  logic        aBigger;

  assign expA     = aReg[30:23];
  assign expB     = bReg[30:23];
  assign mantA    = {|expA, aReg[22:0]};
  assign mantB    = {|expB, bReg[22:0]};
  assign aBigger  = (expA >= expB);
  assign expDiff  = aBigger ? (expA - expB) : (expB - expA);
  assign shiftSrc = aBigger ? mantB : mantA;
  assign shifted  = (expDiff >= 8'd24) ? 24'd0 : (shiftSrc >> expDiff);

  logic [24:0] sum;
  logic        sumSign;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sum     = '0;
    sumSign = bReg[31];
    if (aReg[31] == bReg[31]) begin
      sum     = {1'b0, alA} + {1'b0, alB};
      sumSign = aReg[31];
    end else if (alA > alB) begin
      sum     = {1'b0, alA - alB};
      sumSign = aReg[31];
    end else begin
      sum     = {1'b0, alB - alA};
      sumSign = bReg[31];
    end
  end

  logic [4:0] lz, shiftK;
  logic       normDone;

  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (man[i]) lz = 5'(23 - i);
    end
    shiftK = lz;
    if (shiftK > SHIFT_K) shiftK = SHIFT_K;
    if ({3'b000, shiftK} > exp) shiftK = exp[4:0];
  end

  assign normDone = man[23] | (exp == 8'd0) | (man == 24'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start) nextState = ALIGN;
      ALIGN:   nextState = ADDSUB;
      ADDSUB:  nextState = NORM;
      NORM:    if (normDone) nextState = PACK;
      PACK:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aReg      <= '0;
      bReg      <= '0;
      alA       <= '0;
      alB       <= '0;
      expAl     <= '0;
      man       <= '0;
      exp       <= '0;
      sign      <= 1'b0;
      doneReg   <= 1'b0;
      resultReg <= '0;
    end else begin
      doneReg <= (state == PACK);
      unique case (state)
        IDLE: if (bus.start) begin
          aReg <= bus.a;
          bReg <= bus.b ^ {bus.sub, 31'd0};
        end
        ALIGN: begin
          alA   <= aBigger ? mantA : shifted;
          alB   <= aBigger ? shifted : mantB;
          expAl <= aBigger ? expA : expB;
        end
        ADDSUB: begin
          sign <= sumSign;
          if (sum[24]) begin
            man <= sum[24:1];
            exp <= expAl + 8'd1;
          end else begin
            man <= sum[23:0];
            exp <= expAl;
          end
        end
        NORM: if (!normDone) begin
          man <= man << shiftK;
          exp <= exp - {3'b000, shiftK};
        end
        PACK: begin
          if (man == 24'd0)      resultReg <= 32'd0;
          else if (exp == 8'hFF) resultReg <= {sign, 8'hFF, 23'd0};
          else                   resultReg <= {sign, exp, man[22:0]};
        end
        default: ;
      endcase
    end
  end

`ifdef FP_ADD_SEQ_OPCNT_EN
  logic [15:0] opCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              opCount <= '0;
    else if (state == PACK) opCount <= opCount + 16'd1;
  end

  assign bus.op_count = opCount;
`endif

  assign bus.busy   = (state != IDLE);
  assign bus.done   = doneReg;
  assign bus.result = resultReg;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: one default instance plus a SHIFT_PER_CYC=4 twin.
// op_count checks are compiled in when FP_ADD_SEQ_OPCNT_EN is defined.
module tb_fp_add_seq;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_add_seq_if io ();
  fp_add_seq_if io4 ();

  assign io4.start = io.start;
  assign io4.sub   = io.sub;
  assign io4.a     = io.a;
  assign io4.b     = io.b;

  fp_add_seq #(.SHIFT_PER_CYC(1)) dut  (.clk(clk), .reset(reset), .bus(io));
  fp_add_seq #(.SHIFT_PER_CYC(4)) dut4 (.clk(clk), .reset(reset), .bus(io4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    io.a     = a;
    io.b     = b;
    io.sub   = sub;
    io.start = 1'b1;
  endtask

  // Called #1 after an edge; that next edge is the capture edge N.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub);
    issue(a, b, sub);
    @(posedge clk); #1;
    io.start = 1'b0;
    io.a     = 32'hDEADBEEF;
    io.b     = 32'hC0FFEE00;
    io.sub   = ~sub;
  endtask

  task automatic waitDone(output int lat, output int busyCnt);
    lat     = 0;
    busyCnt = 0;
    while (lat < 60) begin
      if (io.busy) busyCnt++;
      @(posedge clk); #1;
      lat++;
      if (io.done) break;
    end
  endtask

  int lat, busyCnt, lat4, sawDone;

  initial begin
    reset    = 1'b1;
    io.start = 1'b0;
    io.sub   = 1'b0;
    io.a     = '0;
    io.b     = '0;
    #1;
    chk("reset busy",   32'(io.busy),   32'd0);
    chk("reset done",   32'(io.done),   32'd0);
    chk("reset result", io.result,      32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // 1.0 + 1.0
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    waitDone(lat, busyCnt);
    chk("t1 result",  io.result,   32'h40000000);
    chk("t1 latency", 32'(lat),    32'd4);
    chk("t1 busy",    32'(busyCnt), 32'd4);
    chk("t1 busy@done", 32'(io.busy), 32'd0);

    // 1.5 - 1.5 -> +0
    launch(32'h3FC00000, 32'h3FC00000, 1'b1);
    waitDone(lat, busyCnt);
    chk("t2 result",  io.result, 32'h00000000);
    chk("t2 latency", 32'(lat),  32'd4);

    // 1.0 - (1.0 - ulp): 23 normalise shifts at 1/cycle, 6 at 4/cycle
    launch(32'h3F800000, 32'h3F7FFFFF, 1'b1);
    lat  = 60;
    lat4 = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (io4.done) lat4 = c;
      if (io.done) begin
        lat = c;
        break;
      end
    end
    chk("t3 result",     io.result,  32'h34000000);
    chk("t3 latency",    32'(lat),   32'd27);
    chk("t3 result x4",  io4.result, 32'h34000000);
    chk("t3 latency x4", 32'(lat4),  32'd10);

    // Largest finite + itself overflows to +inf
    launch(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    waitDone(lat, busyCnt);
    chk("t4 result",  io.result, 32'h7F800000);
    chk("t4 latency", 32'(lat),  32'd4);

    // Start while busy is dropped; start in the done cycle is accepted
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    @(posedge clk); #1;
    issue(32'h40400000, 32'h40400000, 1'b0);
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("t5 busy after drop", 32'(io.busy), 32'd1);
    waitDone(lat, busyCnt);
    chk("t5 result",  io.result, 32'h40000000);
    chk("t5 latency", 32'(lat),  32'd2);
    launch(32'h40000000, 32'h40000000, 1'b0);
    waitDone(lat, busyCnt);
    chk("t5 b2b result", io.result,     32'h40800000);
    chk("t5 b2b gap",    32'(lat + 1),  32'd5);
    @(posedge clk); #1;
    chk("t5 idle after", 32'(io.busy), 32'd0);

    // Mixed-sign, unequal exponents: 5.0 + (-1.25) = 3.75
    launch(32'h40A00000, 32'hBFA00000, 1'b0);
    waitDone(lat, busyCnt);
    chk("mix result", io.result, 32'h40700000);

    // Reset mid-operation aborts with no done
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6 busy",   32'(io.busy), 32'd0);
    chk("t6 done",   32'(io.done), 32'd0);
    chk("t6 result", io.result,    32'd0);
`ifdef FP_ADD_SEQ_OPCNT_EN
    chk("t6 op_count reset", 32'(io.op_count), 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    sawDone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (io.done) sawDone++;
    end
    chk("t6 no done", 32'(sawDone), 32'd0);

    // Three completed ops after reset: 1+1, 2+2, 3-1
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    waitDone(lat, busyCnt);
    launch(32'h40000000, 32'h40000000, 1'b0);
    waitDone(lat, busyCnt);
    launch(32'h40400000, 32'h3F800000, 1'b1);
    waitDone(lat, busyCnt);
    chk("t6 third result", io.result, 32'h40000000);
`ifdef FP_ADD_SEQ_OPCNT_EN
    chk("t6 op_count", 32'(io.op_count), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
